// File: rtl/link9_pkg.sv
// Shared definitions for the 9-bit parallel byte-frame link (transmitter and
// receiving assembler).
package link9_pkg;

  localparam int BYTE_W  = 8;
  localparam int FRAME_W = 9;

  localparam logic [1:0] NXT_B0 = 2'b01;
  localparam logic [1:0] NXT_B1 = 2'b10;
  localparam logic [1:0] NXT_B2 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_SEND = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Even parity: the low bit makes the total count of ones even.
  function automatic logic [FRAME_W-1:0] frame9(input logic [BYTE_W-1:0] data_byte);
    return {data_byte, ^data_byte};
  endfunction

endpackage

// File: rtl/link_wait_timer.sv
// Loadable up-counter with clear and enable, flagging when the count equals a
// caller-supplied limit.
module link_wait_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         terminal
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)     cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count    = cnt_q;
  assign terminal = (cnt_q == limit);

endmodule

// File: rtl/packet_transmitter.sv
// Sends a 32-bit word as four parity-protected byte frames, MSB first, paced by
// the ready/ack request and the receiver's nxt_data progress index.
module packet_transmitter
  import link9_pkg::*;
#(
  parameter int HOLD_CYCLES    = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        data_in,
  output logic               ready,
  input  logic               ack,
  input  logic [1:0]         nxt_data,
  output logic [FRAME_W-1:0] out_bus_9,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         dbg_state
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;

  logic [15:0]       tmr_limit;
  logic [15:0]       tmr_count;
  logic              tmr_term;
  logic              tmr_load;
  logic              timed_out;
  logic [1:0]        nxt_expect;
  logic [BYTE_W-1:0] cur_byte;

  always_comb begin
    nxt_expect = NXT_B0;
    cur_byte   = word_q[31:24];
    case (idx_q)
      2'd0: begin nxt_expect = NXT_B0; cur_byte = word_q[31:24]; end
      2'd1: begin nxt_expect = NXT_B1; cur_byte = word_q[23:16]; end
      2'd2: begin nxt_expect = NXT_B2; cur_byte = word_q[15:8];  end
      default: begin nxt_expect = NXT_B2; cur_byte = word_q[7:0]; end
    endcase
  end

  // A timeout of zero disables the REQ/SEND watchdog entirely.
  assign timed_out = (TIMEOUT_CYCLES != 0) && tmr_term;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = 2'd0;
        if (start) begin
          word_d  = data_in;
          err_d   = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack) begin
          idx_d   = 2'd0;
          state_d = ST_SEND;
        end else if (timed_out) begin
          state_d = ST_ERR;
        end
      end
      ST_SEND: begin
        if (nxt_data == nxt_expect) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd2) state_d = ST_HOLD;
        end else if (timed_out) begin
          state_d = ST_ERR;
        end
      end
      ST_HOLD: begin
        if (tmr_term) state_d = ST_DONE;
      end
      ST_DONE: begin
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_d   = 1'b1;
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  // One counter: HOLD duration in HOLD, progress watchdog in REQ/SEND.
  assign tmr_limit = (state_q == ST_HOLD) ? 16'(HOLD_CYCLES - 1) : 16'(TIMEOUT_CYCLES);
  assign tmr_load  = (state_d != state_q) || (idx_d != idx_q);

  link_wait_timer #(.W(16)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == ST_IDLE),
    .load     (tmr_load),
    .load_val (16'd0),
    .en       (busy),
    .limit    (tmr_limit),
    .count    (tmr_count),
    .terminal (tmr_term)
  );

  assign ready     = (state_q == ST_REQ) || (state_q == ST_SEND) || (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign out_bus_9 = ((state_q == ST_SEND) || (state_q == ST_HOLD)) ? frame9(cur_byte) : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_packet_transmitter.sv
// Directed bench for packet_transmitter: a default instance plus a
// short-timeout instance for the watchdog scenario.
module tb_packet_transmitter;

  logic        clk = 1'b0;
  logic        rst, start, ack;
  logic [31:0] data_in;
  logic [1:0]  nxt_data;
  logic        ready, busy, done, err;
  logic [8:0]  bus;
  logic [2:0]  dbg_state;

  logic        start2, ack2;
  logic [31:0] data2;
  logic [1:0]  nxt2;
  logic        ready2, busy2, done2, err2;
  logic [8:0]  bus2;
  logic [2:0]  dbg_state2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  packet_transmitter dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ready(ready),
    .ack(ack), .nxt_data(nxt_data), .out_bus_9(bus), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  packet_transmitter #(.HOLD_CYCLES(12), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst(rst), .start(start2), .data_in(data2), .ready(ready2),
    .ack(ack2), .nxt_data(nxt2), .out_bus_9(bus2), .busy(busy2), .done(done2),
    .err(err2), .dbg_state(dbg_state2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ack = 1'b0; nxt_data = 2'b00; data_in = '0;
    start2 = 1'b0; ack2 = 1'b0; nxt2 = 2'b00; data2 = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({ready, bus, busy, done, err} !== 13'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0", {ready, bus, busy, done, err});
    end
    n_cmp++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
  endtask

  // Immediate ack, each nxt_data step two cycles after its frame appears.
  task automatic test_basic();
    logic [8:0] exp_f [4];
    exp_f[0] = 9'h14A; exp_f[1] = 9'h078; exp_f[2] = 9'h003; exp_f[3] = 9'h1FE;
    start = 1'b1; data_in = 32'hA53C01FF;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({ready, busy, bus} !== {2'b11, 9'h000}) begin
      n_fail++; $display("FAIL basic_req: got ready=%b busy=%b bus=%h want 1 1 000", ready, busy, bus);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus !== exp_f[i]) begin
        n_fail++; $display("FAIL basic_frame%0d: got %h want %h", i, bus, exp_f[i]);
      end
      tick();
      n_cmp++;
      if (bus !== exp_f[i]) begin
        n_fail++; $display("FAIL basic_frame%0d_hold: got %h want %h", i, bus, exp_f[i]);
      end
      nxt_data = 2'(i + 1);
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if ({bus, done, ready} !== {exp_f[3], 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL basic_hold%0d: got bus=%h done=%b ready=%b want %h 0 1", i, bus, done, ready, exp_f[3]);
      end
      tick();
    end
    n_cmp++;
    if ({done, ready, bus, err} !== {1'b1, 1'b0, 9'h000, 1'b0}) begin
      n_fail++; $display("FAIL basic_done: got done=%b ready=%b bus=%h err=%b want 1 0 000 0", done, ready, bus, err);
    end
    tick();
    n_cmp++;
    if ({done, busy, err} !== 3'b000) begin
      n_fail++; $display("FAIL basic_idle: got done=%b busy=%b err=%b want 0 0 0", done, busy, err);
    end
  endtask

  task automatic test_ack_delay();
    int bad;
    bool_wait: begin end
    bad = 0;
    start = 1'b1; data_in = 32'hA53C01FF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready !== 1'b1 || bus !== 9'h000) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL ackdelay_wait: got %0d bad cycles want 0", bad);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++;
    if (bus !== 9'h14A) begin
      n_fail++; $display("FAIL ackdelay_frame0: got %h want 14a", bus);
    end
    nxt_data = 2'b01; tick();
    nxt_data = 2'b10; tick();
    nxt_data = 2'b11; tick();
    n_cmp++;
    if (bus !== 9'h1FE) begin
      n_fail++; $display("FAIL ackdelay_frame3: got %h want 1fe", bus);
    end
    for (int i = 0; i < 12; i++) tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL ackdelay_done: got %b want 1", done);
    end
    tick();
  endtask

  // nxt_data is still 11 from the previous word when this one starts.
  task automatic test_stale_nxt();
    int seen;
    n_cmp++;
    if (nxt_data !== 2'b11) begin
      n_fail++; $display("FAIL stale_setup: got %b want 11", nxt_data);
    end
    start = 1'b1; data_in = 32'hDEADBEEF;
    tick();
    start = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus !== 9'h1BC) begin
        n_fail++; $display("FAIL stale_frame0_c%0d: got %h want 1bc", i, bus);
      end
      tick();
    end
    nxt_data = 2'b01; tick();
    n_cmp++;
    if (bus !== 9'h15B) begin
      n_fail++; $display("FAIL stale_frame1: got %h want 15b", bus);
    end
    nxt_data = 2'b10; tick();
    n_cmp++;
    if (bus !== 9'h17C) begin
      n_fail++; $display("FAIL stale_frame2: got %h want 17c", bus);
    end
    nxt_data = 2'b11; tick();
    n_cmp++;
    if (bus !== 9'h1DF) begin
      n_fail++; $display("FAIL stale_frame3: got %h want 1df", bus);
    end
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (done === 1'b1) seen = 1;
      else tick();
    end
    n_cmp++;
    if (seen != 1) begin
      n_fail++; $display("FAIL stale_done: got no done want done within 20 cycles");
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int seen;
    start = 1'b1; data_in = 32'h11223344;
    tick();
    start = 1'b0; ack = 1'b1; nxt_data = 2'b00;
    tick();
    ack = 1'b0;
    start = 1'b1; data_in = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({bus, busy} !== {9'h022, 1'b1}) begin
      n_fail++; $display("FAIL ignore_frame0: got bus=%h busy=%b want 022 1", bus, busy);
    end
    nxt_data = 2'b01; tick();
    n_cmp++;
    if (bus !== 9'h044) begin
      n_fail++; $display("FAIL ignore_frame1: got %h want 044", bus);
    end
    nxt_data = 2'b10; tick();
    n_cmp++;
    if (bus !== 9'h066) begin
      n_fail++; $display("FAIL ignore_frame2: got %h want 066", bus);
    end
    nxt_data = 2'b11; tick();
    n_cmp++;
    if (bus !== 9'h088) begin
      n_fail++; $display("FAIL ignore_frame3: got %h want 088", bus);
    end
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (done === 1'b1) seen = 1;
      else tick();
    end
    n_cmp++;
    if (seen != 1) begin
      n_fail++; $display("FAIL ignore_done: got no done want done within 20 cycles");
    end
    tick();
    // Back-to-back: IDLE right after DONE accepts a new word.
    start = 1'b1; data_in = 32'h00000000;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, ready} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b ready=%b want 1 1", busy, ready);
    end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int frames_ok;
    int seen;
    nxt_data = 2'b00;
    start = 1'b1; data_in = 32'h11223344;
    tick();
    start = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    nxt_data = 2'b01; tick();
    nxt_data = 2'b10; tick();
    n_cmp++;
    if (bus !== 9'h066) begin
      n_fail++; $display("FAIL rstmid_frame2: got %h want 066", bus);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({ready, bus, busy, done, err, dbg_state} !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b want 0", {ready, bus, busy, done, err, dbg_state});
    end
    nxt_data = 2'b00;
    start = 1'b1; data_in = 32'h00000000;
    tick();
    start = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    frames_ok = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus === 9'h000 && busy === 1'b1 && ready === 1'b1) frames_ok++;
      nxt_data = 2'(i + 1);
      tick();
    end
    n_cmp++;
    if (frames_ok != 4) begin
      n_fail++; $display("FAIL rstmid_zero_frames: got %0d good frames want 4", frames_ok);
    end
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (done === 1'b1) seen = 1;
      else tick();
    end
    n_cmp++;
    if (seen != 1) begin
      n_fail++; $display("FAIL rstmid_done: got no done want done within 20 cycles");
    end
    tick();
  endtask

  task automatic test_timeout();
    int seen_err;
    int seen_done;
    start2 = 1'b1; data2 = 32'hCAFEF00D;
    tick();
    start2 = 1'b0;
    seen_err = 0; seen_done = 0;
    for (int i = 0; i < 100 && seen_err == 0; i++) begin
      if (done2 === 1'b1) seen_done = 1;
      if (err2 === 1'b1) seen_err = 1;
      else tick();
    end
    n_cmp++;
    if (seen_err != 1) begin
      n_fail++; $display("FAIL timeout_err: got err=%b want 1 within 100 cycles", err2);
    end
    n_cmp++;
    if ({ready2, busy2, seen_done[0]} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_idle: got ready=%b busy=%b done_seen=%0d want 0 0 0", ready2, busy2, seen_done);
    end
    tick();
    n_cmp++;
    if (err2 !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b want 1", err2);
    end
    start2 = 1'b1; data2 = 32'h0;
    tick();
    start2 = 1'b0;
    n_cmp++;
    if ({err2, busy2} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_clear: got err=%b busy=%b want 0 1", err2, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_stale_nxt();
    test_start_ignored();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_transmitter.md
# packet_transmitter

Sending end of the 9-bit parallel byte-frame link. Accepts a 32-bit word and sends it as four frames, most significant byte first. Each frame is 8 data bits plus an even-parity bit. The link is paced by the ready/ack request handshake and by the receiver's 2-bit `nxt_data` progress index. The block sits on the source side of the link and is the counterpart of the receiving assembler, which rebuilds `stored_data` from these frames.

## Interface
Parameters:
- `HOLD_CYCLES`, 12: cycles the final frame stays on the bus before completion (last byte has no distinct `nxt_data` step).
- `TIMEOUT_CYCLES`, 255: maximum cycles spent waiting for `ack` or a `nxt_data` step; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to send `data_in`; honoured only in IDLE.
- `data_in` in 32: word to send, latched on the accepted `start`.
- `ready` out 1: link request to the receiver.
- `ack` in 1: receiver grants the request.
- `nxt_data` in 2: receiver progress index: 01, 10 and 11 after storing bytes 0, 1 and 2.
- `out_bus_9` out 9: frame; [8:1] is the data byte, [0] is parity (XOR of [8:1]).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a word completes.
- `err` out 1: sticky timeout flag, cleared by the next accepted `start` or by `rst`.

## Operation
- State machine: IDLE, REQ, SEND, HOLD, DONE, ERR.
- IDLE: if `start` is high, latch `data_in` into `word_q`, clear `err`, and go to REQ.
- REQ: drive `ready`=1 and wait for `ack`=1, then go to SEND with byte index `idx`=0.
- SEND, with `idx` 0..2:
  - Drive `out_bus_9` = {`word_q` byte `idx`, parity}; byte 0 is [31:24].
  - When `nxt_data` == `idx`+1, increment `idx`.
  - When `idx` becomes 3, go to HOLD.
- HOLD: drive byte 3 ([7:0]) for `HOLD_CYCLES` cycles, then go to DONE.
- DONE: pulse `done`, drop `ready`, return to IDLE.
- Timeout: one wait counter serves REQ and SEND. It clears on every state or `idx` change. When it reaches `TIMEOUT_CYCLES`, go to ERR.
- ERR: set `err`, drop `ready`, return to IDLE on the next cycle.
- `nxt_data` values other than `idx`+1 are ignored; this includes a stale 11 left from a previous word.
- `ack` is only examined in REQ.
- `start` while `busy` is ignored and does not change `word_q`.
- `rst` in any state, mid-word included, forces IDLE on the next edge. All outputs then read zero; a partial word is discarded with no `done` or `err`.

## Timing
- Reset values: `ready`=0, `out_bus_9`=0, `busy`=0, `done`=0, `err`=0, `idx`=0.
- `start` accepted at edge N: `ready`=1 and `busy`=1 from N+1.
- `ack` sampled high at edge M: frame 0 valid from M+1.
- `nxt_data` step sampled at edge K: next frame valid from K+1.
- `ready` stays high from REQ through HOLD and is low in DONE, ERR and IDLE.
- Frame 3 is visible for exactly `HOLD_CYCLES` cycles; `done` is high the following cycle.
- `out_bus_9` returns to 0 in IDLE.
- Minimum word latency (`ack` and steps immediate), `start` to `done`: 1+1+3+`HOLD_CYCLES`+1 = 18 cycles at default.
- Back-to-back: `start` may be accepted in the cycle after `done`, once the block is in IDLE.
- Timeout: ERR entered when the wait counter reaches `TIMEOUT_CYCLES` without progress; `err` rises the cycle after.

## Structure
- Shared package `link9_pkg` holds:
  - state enum;
  - `BYTE_W`=8 and `FRAME_W`=9;
  - `NXT_B0`=2'b01, `NXT_B1`=2'b10, `NXT_B2`=2'b11;
  - function `frame9(byte)` returning {byte, ^byte}.
- The receiving assembler uses the same package.
- One sub-module, `link_wait_timer`: loadable up-counter with clear, enable and terminal flag. It is used for both the timeout and the HOLD count.

## Test plan
- Word 0xA5_3C_01_FF, `ack` immediate, each step two cycles later → frames 0x14A, 0x078, 0x003, 0x1FE in order; `done` pulse 1 cycle; `err`=0.
- `ack` delayed 40 cycles → `ready` held high and bus 0 throughout; frame 0 = {0xA5,0} appears the cycle after `ack`.
- `ack` never asserted with `TIMEOUT_CYCLES`=16 → `err`=1, `ready`=0, `busy`=0, no `done`; the next `start` clears `err`.
- `nxt_data` stuck at 11 from the previous word, then steps 01, 10, 11 → stale 11 is ignored and all four bytes are sent in order.
- `rst` asserted while byte 2 is on the bus → next cycle all outputs 0 and IDLE; a fresh `start` with 0x00000000 sends frames 0x000 ×4.
- `start` pulsed during SEND with a new word → ignored; the original word completes unchanged.
